// File: rtl/ps2_pkg.sv
// Shared encodings and scan-code constants for the PS/2 keyboard controller.
package ps2_pkg;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_POP  = 1'b1
    } fetch_state_t;

    typedef enum logic [2:0] {
        P_BASE   = 3'd0,
        P_EXT    = 3'd1,
        P_BRK    = 3'd2,
        P_EXTBRK = 3'd3,
        P_PAUSE  = 3'd4
    } parse_state_t;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;
    localparam logic [7:0] KEY_CAPS   = 8'h58;

    // Index 0 = shift, 1 = ctrl, 2 = alt; left side never carries E0
    localparam logic [2:0][7:0] MOD_L_CODE = {8'h11, 8'h14, 8'h12};
    localparam logic [2:0][7:0] MOD_R_CODE = {8'h11, 8'h14, 8'h59};
    localparam logic [2:0]      MOD_R_EXT  = 3'b110;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PFX_EXT) || (b == PFX_PAUSE) || (b == PFX_BRK);
    endfunction

    // Keyboard status/handshake bytes that never represent a key
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_mod_track.sv
// Side-resolved modifier and caps-lock tracking, updated on each emitted key event.
module ps2_mod_track
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       strobe,
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       brk,
    output logic [3:0] mods
);

    logic [2:0] side_any;
    logic       caps_reg;
    logic       caps_held_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mod
            logic held_l_reg;
            logic held_r_reg;

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    held_l_reg <= 1'b0;
                    held_r_reg <= 1'b0;
                end else if (strobe) begin
                    if (code == MOD_L_CODE[gi] && !ext)
                        held_l_reg <= !brk;
                    if (code == MOD_R_CODE[gi] && ext == MOD_R_EXT[gi])
                        held_r_reg <= !brk;
                end
            end

            assign side_any[gi] = held_l_reg | held_r_reg;
        end
    endgenerate

    // Typematic repeats of caps keep caps_held set and therefore do not toggle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            caps_reg      <= 1'b0;
            caps_held_reg <= 1'b0;
        end else if (strobe && code == KEY_CAPS && !ext) begin
            if (brk) begin
                caps_held_reg <= 1'b0;
            end else begin
                caps_held_reg <= 1'b1;
                if (!caps_held_reg)
                    caps_reg <= ~caps_reg;
            end
        end
    end

    assign mods = {caps_reg, side_any[2], side_any[1], side_any[0]};

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: pops scan bytes from a keyboard FIFO, strips
// prefixes into key events with ack handshake, tracks modifiers and errors.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter bit IGNORE_PAUSE = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       kb_ready,
    input  logic [7:0] kb_data,
    input  logic       kb_overflow,
    output logic       kb_rdn,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    input  logic       ev_ack,
    output logic [3:0] mods,
    output logic       err,
    input  logic       err_clr
);

    fetch_state_t fetch_reg, fetch_next;
    parse_state_t parse_reg, parse_next;
    logic [2:0]   skip_reg, skip_next;
    logic         kb_rdn_reg;
    logic         ev_valid_reg;
    logic [7:0]   ev_code_reg;
    logic         ev_ext_reg;
    logic         ev_break_reg;
    logic         err_reg, err_next;
    logic         pop_go, ovf_hit, proto_err;
    logic         emit, emit_ext, emit_brk;
    logic [7:0]   emit_code;

    // Fetch FSM: kb_data is consumed on the IDLE->POP edge itself
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_reg  <= F_IDLE;
            kb_rdn_reg <= 1'b1;
        end else begin
            fetch_reg  <= fetch_next;
            kb_rdn_reg <= (fetch_next != F_POP);
        end
    end

    always_comb begin
        fetch_next = fetch_reg;
        case (fetch_reg)
            F_IDLE:  if (pop_go) fetch_next = F_POP;
            F_POP:   fetch_next = F_IDLE;
            default: fetch_next = F_IDLE;
        endcase
    end

    always_comb begin
        ovf_hit = (fetch_reg == F_IDLE) && kb_overflow;
        pop_go  = (fetch_reg == F_IDLE) && kb_ready && !kb_overflow &&
                  (!ev_valid_reg || ev_ack);
    end

    // Parser state register plus event, error and skip state
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            parse_reg    <= P_BASE;
            skip_reg     <= 3'd0;
            err_reg      <= 1'b0;
            ev_valid_reg <= 1'b0;
            ev_code_reg  <= 8'h00;
            ev_ext_reg   <= 1'b0;
            ev_break_reg <= 1'b0;
        end else begin
            parse_reg <= parse_next;
            skip_reg  <= skip_next;
            err_reg   <= err_next;
            if (pop_go && emit) begin
                ev_valid_reg <= 1'b1;
                ev_code_reg  <= emit_code;
                ev_ext_reg   <= emit_ext;
                ev_break_reg <= emit_brk;
            end else if (ev_ack) begin
                ev_valid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        parse_next = parse_reg;
        skip_next  = skip_reg;
        proto_err  = 1'b0;
        if (ovf_hit) begin
            parse_next = P_BASE;
            skip_next  = 3'd0;
        end else if (pop_go) begin
            case (parse_reg)
                P_BASE: begin
                    if (kb_data == PFX_EXT) begin
                        parse_next = P_EXT;
                    end else if (kb_data == PFX_BRK) begin
                        parse_next = P_BRK;
                    end else if (kb_data == PFX_PAUSE) begin
                        parse_next = P_PAUSE;
                        skip_next  = PAUSE_SKIP;
                    end
                end
                P_EXT: begin
                    if (kb_data == PFX_BRK) begin
                        parse_next = P_EXTBRK;
                    end else begin
                        parse_next = P_BASE;
                        proto_err  = (kb_data == PFX_EXT) || (kb_data == PFX_PAUSE);
                    end
                end
                P_BRK, P_EXTBRK: begin
                    parse_next = P_BASE;
                    proto_err  = is_prefix(kb_data);
                end
                P_PAUSE: begin
                    if (skip_reg <= 3'd1) begin
                        parse_next = P_BASE;
                        skip_next  = 3'd0;
                    end else begin
                        skip_next = skip_reg - 3'd1;
                    end
                end
                default: parse_next = P_BASE;
            endcase
        end
    end

    always_comb begin
        emit      = 1'b0;
        emit_code = kb_data;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        if (pop_go) begin
            case (parse_reg)
                P_BASE:   emit = !is_prefix(kb_data) && !is_discard(kb_data);
                P_EXT: begin
                    emit     = !is_prefix(kb_data);
                    emit_ext = 1'b1;
                end
                P_BRK: begin
                    emit     = !is_prefix(kb_data);
                    emit_brk = 1'b1;
                end
                P_EXTBRK: begin
                    emit     = !is_prefix(kb_data);
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
                P_PAUSE: begin
                    emit      = (skip_reg <= 3'd1) && !IGNORE_PAUSE;
                    emit_code = PFX_PAUSE;
                end
                default: emit = 1'b0;
            endcase
        end
    end

    // A new error wins over a simultaneous clear
    always_comb begin
        err_next = err_reg;
        if (proto_err || ovf_hit)
            err_next = 1'b1;
        else if (err_clr)
            err_next = 1'b0;
    end

    ps2_mod_track u_mod_track (
        .clk    (clk),
        .clrn   (clrn),
        .strobe (pop_go && emit),
        .code   (emit_code),
        .ext    (emit_ext),
        .brk    (emit_brk),
        .mods   (mods)
    );

    assign kb_rdn   = kb_rdn_reg;
    assign ev_valid = ev_valid_reg;
    assign ev_code  = ev_code_reg;
    assign ev_ext   = ev_ext_reg;
    assign ev_break = ev_break_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: FIFO model, event/pop monitors, scripted scenarios.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       kb_ready = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_overflow = 1'b0;
    logic       ev_ack = 1'b1;
    logic       err_clr = 1'b0;

    logic       kb_rdn, ev_valid, ev_ext, ev_break, err;
    logic [7:0] ev_code;
    logic [3:0] mods;

    logic       kb_rdn_np, ev_valid_np, ev_ext_np, ev_break_np, err_np;
    logic [7:0] ev_code_np;
    logic [3:0] mods_np;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fifo_q[$];
    logic [9:0] ev_q[$];
    logic [9:0] ev2_q[$];
    int         rdn_low = 0, rdn_pulses = 0, rdn_long = 0;
    logic       rdn_prev = 1'b1;

    ps2_kbd_ctrl #(.IGNORE_PAUSE(1'b1)) u_dut (
        .clk(clk), .clrn(clrn), .kb_ready(kb_ready), .kb_data(kb_data),
        .kb_overflow(kb_overflow), .kb_rdn(kb_rdn), .ev_valid(ev_valid),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .ev_ack(ev_ack), .mods(mods), .err(err), .err_clr(err_clr)
    );

    ps2_kbd_ctrl #(.IGNORE_PAUSE(1'b0)) u_dut_np (
        .clk(clk), .clrn(clrn), .kb_ready(kb_ready), .kb_data(kb_data),
        .kb_overflow(kb_overflow), .kb_rdn(kb_rdn_np), .ev_valid(ev_valid_np),
        .ev_code(ev_code_np), .ev_ext(ev_ext_np), .ev_break(ev_break_np),
        .ev_ack(ev_ack), .mods(mods_np), .err(err_np), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Keyboard FIFO model: pops on the edge that ends a kb_rdn-low cycle
    always @(posedge clk) begin
        if (!kb_rdn && fifo_q.size() != 0)
            void'(fifo_q.pop_front());
    end

    always @(negedge clk) begin
        kb_ready = (fifo_q.size() != 0);
        kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (ev_valid && ev_ack)
            ev_q.push_back({ev_code, ev_ext, ev_break});
        if (ev_valid_np && ev_ack)
            ev2_q.push_back({ev_code_np, ev_ext_np, ev_break_np});
        if (!kb_rdn) begin
            rdn_low++;
            if (rdn_prev) rdn_pulses++;
            else rdn_long++;
        end
        rdn_prev = kb_rdn;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic clear_mon();
        ev_q.delete();
        ev2_q.delete();
        rdn_low    = 0;
        rdn_pulses = 0;
        rdn_long   = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((fifo_q.size() != 0 || !kb_rdn || kb_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_drain_timeout"}, (n >= 500) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic send1(input logic [7:0] b, input string tag);
        fifo_q.push_back(b);
        wait_idle(tag);
    endtask

    function automatic logic [31:0] ev_at(input int idx);
        return (idx < ev_q.size()) ? {22'd0, ev_q[idx]} : 32'hDEAD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_kb_rdn", kb_rdn, 1);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_code", ev_code, 8'h00);
        check("rst_ev_ext", ev_ext, 0);
        check("rst_ev_break", ev_break, 0);
        check("rst_mods", mods, 4'h0);
        check("rst_err", err, 0);
        clrn = 1'b1;
        @(negedge clk);

        // Make and break of a plain key, immediate ack
        clear_mon();
        fifo_q.push_back(8'h1C); fifo_q.push_back(8'hF0); fifo_q.push_back(8'h1C);
        wait_idle("t1");
        check("t1_nev", ev_q.size(), 2);
        check("t1_ev0", ev_at(0), {8'h1C, 1'b0, 1'b0});
        check("t1_ev1", ev_at(1), {8'h1C, 1'b0, 1'b1});
        check("t1_pulses", rdn_pulses, 3);
        check("t1_low_cycles", rdn_low, 3);
        check("t1_long_pulse", rdn_long, 0);

        // Extended make and break
        clear_mon();
        fifo_q.push_back(8'hE0); fifo_q.push_back(8'h75);
        fifo_q.push_back(8'hE0); fifo_q.push_back(8'hF0); fifo_q.push_back(8'h75);
        wait_idle("t2");
        check("t2_nev", ev_q.size(), 2);
        check("t2_ev0", ev_at(0), {8'h75, 1'b1, 1'b0});
        check("t2_ev1", ev_at(1), {8'h75, 1'b1, 1'b1});
        check("t2_mods", mods, 4'h0);
        check("t2_err", err, 0);

        // Caps lock with typematic repeat
        clear_mon();
        send1(8'h58, "caps_a");                  check("caps_make", mods, 4'h8);
        send1(8'h58, "caps_b");                  check("caps_repeat", mods, 4'h8);
        fifo_q.push_back(8'hF0); send1(8'h58, "caps_c"); check("caps_break", mods, 4'h8);
        send1(8'h58, "caps_d");                  check("caps_make2", mods, 4'h0);
        check("caps_nev", ev_q.size(), 4);

        // Side-resolved shift/ctrl/alt
        send1(8'h12, "m1");                      check("lshift", mods, 4'h1);
        send1(8'h14, "m2");                      check("lctrl", mods, 4'h3);
        fifo_q.push_back(8'hE0); send1(8'h14, "m3"); check("rctrl", mods, 4'h3);
        fifo_q.push_back(8'hE0); fifo_q.push_back(8'hF0); send1(8'h14, "m4");
        check("rctrl_up_lctrl_held", mods, 4'h3);
        fifo_q.push_back(8'hF0); send1(8'h14, "m5"); check("lctrl_up", mods, 4'h1);
        fifo_q.push_back(8'hE0); send1(8'h11, "m6"); check("ralt", mods, 4'h5);
        fifo_q.push_back(8'hF0); send1(8'h12, "m7"); check("lshift_up", mods, 4'h4);
        fifo_q.push_back(8'hE0); fifo_q.push_back(8'hF0); send1(8'h11, "m8");
        check("ralt_up", mods, 4'h0);
        send1(8'h59, "m9");                      check("rshift", mods, 4'h1);
        fifo_q.push_back(8'hF0); send1(8'h59, "m10"); check("rshift_up", mods, 4'h0);

        // Status bytes are discarded
        clear_mon();
        fifo_q.push_back(8'h00); fifo_q.push_back(8'hAA); fifo_q.push_back(8'hEE);
        fifo_q.push_back(8'hFA); fifo_q.push_back(8'hFE); fifo_q.push_back(8'hFF);
        wait_idle("disc");
        check("discard_nev", ev_q.size(), 0);

        // Pause sequence: swallowed vs one E1 event
        clear_mon();
        fifo_q.push_back(8'hE1); fifo_q.push_back(8'h14); fifo_q.push_back(8'h77);
        fifo_q.push_back(8'hE1); fifo_q.push_back(8'hF0); fifo_q.push_back(8'h14);
        fifo_q.push_back(8'hF0); fifo_q.push_back(8'h77);
        wait_idle("pause");
        check("pause_ign_nev", ev_q.size(), 0);
        check("pause_np_nev", ev2_q.size(), 1);
        check("pause_np_ev", (ev2_q.size() != 0) ? {22'd0, ev2_q[0]} : 32'hDEAD,
              {8'hE1, 1'b0, 1'b0});
        check("pause_err", err, 0);
        clear_mon();
        send1(8'h1C, "pause_after");
        check("pause_after_ev", ev_at(0), {8'h1C, 1'b0, 1'b0});

        // Backpressure: held event, no pops until ack
        clear_mon();
        @(posedge clk); #2 ev_ack = 1'b0;
        fifo_q.push_back(8'h2A); fifo_q.push_back(8'h2B); fifo_q.push_back(8'h2C);
        repeat (20) @(negedge clk);
        check("bp_valid", ev_valid, 1);
        check("bp_code", ev_code, 8'h2A);
        check("bp_flags", {ev_ext, ev_break}, 2'b00);
        check("bp_pulses", rdn_pulses, 1);
        check("bp_fifo_left", fifo_q.size(), 2);
        check("bp_rdn_high", kb_rdn, 1);
        @(posedge clk); #2 ev_ack = 1'b1;
        @(posedge clk); #2 ev_ack = 1'b0;
        @(negedge clk);
        check("bp_ack_pop", kb_rdn, 0);
        check("bp_ack_valid", ev_valid, 1);
        check("bp_ack_code", ev_code, 8'h2B);
        ev_q.delete();
        @(posedge clk); #2 ev_ack = 1'b1;
        wait_idle("bp_drain");
        check("bp_drain_nev", ev_q.size(), 2);
        check("bp_drain_ev0", ev_at(0), {8'h2B, 1'b0, 1'b0});
        check("bp_drain_ev1", ev_at(1), {8'h2C, 1'b0, 1'b0});

        // Overflow in the middle of E0 F0 drops the prefix
        clear_mon();
        fifo_q.push_back(8'hE0); fifo_q.push_back(8'hF0);
        wait_idle("ovf_pfx");
        @(posedge clk); #2 kb_overflow = 1'b1;
        @(posedge clk); #2 kb_overflow = 1'b0;
        @(negedge clk);
        check("ovf_err", err, 1);
        send1(8'h1C, "ovf_next");
        check("ovf_next_ev", ev_at(0), {8'h1C, 1'b0, 1'b0});
        check("ovf_err_sticky", err, 1);
        @(posedge clk); #2 err_clr = 1'b1;
        @(posedge clk); #2 err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", err, 0);

        // Protocol violation: E0 after F0
        clear_mon();
        fifo_q.push_back(8'hF0); fifo_q.push_back(8'hE0);
        wait_idle("proto");
        check("proto_err", err, 1);
        check("proto_nev", ev_q.size(), 0);
        send1(8'h1C, "proto_next");
        check("proto_next_ev", ev_at(0), {8'h1C, 1'b0, 1'b0});
        @(posedge clk); #2 err_clr = 1'b1;
        @(posedge clk); #2 err_clr = 1'b0;

        // Asynchronous reset in the middle of a POP cycle
        clear_mon();
        send1(8'h12, "rst_shift");
        fifo_q.push_back(8'hE0);
        wait_idle("rst_pfx");
        check("rst_pre_mods", mods, 4'h1);
        fifo_q.push_back(8'h1C);
        n = 0;
        while (kb_rdn && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_pop_seen", kb_rdn, 0);
        check("rst_pop_valid", ev_valid, 1);
        #1 clrn = 1'b0;
        #1;
        check("rst_async_rdn", kb_rdn, 1);
        check("rst_async_valid", ev_valid, 0);
        check("rst_async_code", ev_code, 8'h00);
        check("rst_async_mods", mods, 4'h0);
        fifo_q.delete();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        clear_mon();
        send1(8'h1C, "rst_after");
        check("rst_after_ev", ev_at(0), {8'h1C, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Parameter: IGNORE_PAUSE, 1, when 1 the Pause sequence is swallowed; when 0 it yields one event with code 8'hE1.
REQ-002 clk  in  1  system clock (50 MHz), all state on rising edge.
REQ-003 clrn  in  1  asynchronous, active-low reset.
REQ-004 kb_ready  in  1  keyboard FIFO not empty.
REQ-005 kb_data  in  8  keyboard FIFO head byte, valid while kb_ready=1.
REQ-006 kb_overflow  in  1  keyboard FIFO overflow flag.
REQ-007 kb_rdn  out  1  FIFO pop strobe, active low, registered.
REQ-008 ev_valid  out  1  key event pending.
REQ-009 ev_code  out  8  scan code, prefixes stripped.
REQ-010 ev_ext  out  1  event carried E0 prefix.
REQ-011 ev_break  out  1  1 = key release, 0 = press/repeat.
REQ-012 ev_ack  in  1  consumer accepts event.
REQ-013 mods  out  4  {caps_lock, alt, ctrl, shift}.
REQ-014 err  out  1  sticky error (overflow or protocol violation).
REQ-015 err_clr  in  1  clears err.

Function
REQ-016 Fetch FSM states IDLE, POP; IDLE->POP when kb_ready=1 and (ev_valid=0 or ev_ack=1); kb_data captured on that edge.
REQ-017 kb_rdn SHALL be 0 for exactly the one POP cycle, 1 otherwise; POP->IDLE unconditionally; max throughput one byte per 2 cycles.
REQ-018 Parser states BASE, EXT (after E0), BRK (after F0), EXTBRK (E0 F0), PAUSE (skip counter 3 bits).
REQ-019 BASE: E0->EXT, F0->BRK, E1->PAUSE with skip=7; bytes 00, AA, EE, FA, FE, FF discarded; else event {code, ext=0, break=0}.
REQ-020 EXT: F0->EXTBRK; other byte -> event ext=1, break=0, ->BASE. BRK: event ext=0, break=1, ->BASE. EXTBRK: event ext=1, break=1, ->BASE.
REQ-021 E0, E1 or F0 received in BRK/EXTBRK, or E0/E1 in EXT: set err, return to BASE, no event.
REQ-022 PAUSE: each byte decrements skip; at skip 1->0 return to BASE and, if IGNORE_PAUSE=0, emit code E1, ext=0, break=0.
REQ-023 Event outputs registered; ev_valid rises in the POP cycle of the completing byte; ev_code/ev_ext/ev_break stable while ev_valid=1.
REQ-024 ev_valid clears on the edge where ev_ack=1; ack and a new capture on the same edge SHALL both take effect (back-to-back events, no lost byte).
REQ-025 ev_ack while ev_valid=0 SHALL be ignored.
REQ-026 No pop while an unacked event is held: backpressure propagates into the keyboard FIFO.
REQ-027 Modifiers update in the same edge the event is emitted: shift = L(12) or R(59) held; ctrl = 14 or E0 14 held; alt = 11 or E0 11 held; tracked per side, OR-ed to mods.
REQ-028 caps_lock toggles on a make of 58 only if 58 not already held (typematic repeats do not toggle); break of 58 clears held flag.
REQ-029 kb_overflow=1 sampled in IDLE: parser -> BASE, skip cleared, err set; any held event remains valid.
REQ-030 err_clr=1 clears err unless a new error occurs the same edge (set wins).

Reset
REQ-031 On clrn=0, immediately: kb_rdn=1, ev_valid=0, ev_code=8'h00, ev_ext=0, ev_break=0, mods=4'h0, err=0, fetch FSM IDLE, parser BASE, skip=0.
REQ-032 Reset during POP SHALL force kb_rdn high asynchronously; partial prefix sequences are discarded.

Structure
REQ-033 Shared package ps2_pkg holds parser/fetch state encodings and constants: prefixes E0, E1, F0, discard codes, modifier codes 12, 59, 14, 11, 58.
REQ-034 One sub-module ps2_mod_track: holds side-resolved modifier and caps state, driven by {code, ext, break, strobe}.

Verification
REQ-035 FIFO bytes 1C, F0 1C, acked immediately -> events {1C,0,0}, {1C,0,1}; kb_rdn pulses 3 times, each 1 cycle low.
REQ-036 Bytes E0 75, E0 F0 75 -> {75,1,0}, {75,1,1}; mods unchanged; err=0.
REQ-037 Bytes 58 58 F0 58 58 -> caps_lock 0->1 (stays 1 on repeat) ->1 after break ->0 on second make.
REQ-038 Hold ev_ack=0 for 20 cycles with 3 bytes queued -> single event held stable, kb_rdn stays 1; ack pulse -> next byte popped same edge.
REQ-039 E1 14 77 E1 F0 14 F0 77 with IGNORE_PAUSE=1 -> no events, parser back in BASE; with 0 -> one event {E1,0,0}.
REQ-040 kb_overflow pulse mid E0 F0 sequence -> err=1, next byte 1C yields {1C,0,0}; err_clr -> err=0; clrn low mid-POP -> kb_rdn=1 immediately.
